// File: rtl/matrix_sender_arbiter.sv
// Session arbiter for the shared matrix UART sender: round-robin ownership per print session,
// one element in flight at a time, done routed back to the owner, watchdog on stalled sends.
module matrix_sender_arbiter #(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned OW          = $clog2(N_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    cli_req,
  input  logic [N_REQ-1:0]                    cli_start,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    cli_data,
  input  logic [N_REQ-1:0][4:0]               cli_flags,
  output logic [N_REQ-1:0]                    cli_grant,
  output logic [N_REQ-1:0]                    cli_done,
  output logic [DATA_WIDTH-1:0]               snd_data,
  output logic [4:0]                          snd_flags,
  output logic                                snd_start,
  input  logic                                snd_done,
  output logic                                busy,
  output logic [OW-1:0]                       owner_id,
  output logic                                timeout_err,
  output logic                                proto_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StGranted, StInFlight, StRelease} state_e;

  state_e                  state_q, state_d;
  logic [N_REQ-1:0]        grant_q, grant_d;
  logic [N_REQ-1:0]        done_q, done_d;
  logic [DATA_WIDTH-1:0]   snd_data_q, snd_data_d;
  logic [4:0]              snd_flags_q, snd_flags_d;
  logic                    snd_start_q, snd_start_d;
  logic                    busy_q, busy_d;
  logic [OW-1:0]           owner_q, owner_d;
  logic [OW-1:0]           last_q, last_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    tmo_q, tmo_d;
  logic                    perr_q, perr_d;

  logic                    rr_found;
  logic [OW-1:0]           rr_idx;
  logic [OW-1:0]           rr_winner;
  logic [N_REQ-1:0]        legal_start;

  // Round-robin search starting just after the previous owner, wrapping around.
  always_comb begin
    rr_found  = 1'b0;
    rr_idx    = '0;
    rr_winner = last_q;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      rr_idx = OW'((32'(last_q) + i) % N_REQ);
      if (!rr_found && cli_req[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx;
      end
    end
  end

  // Only the owner may start, and only while no element is in flight.
  assign legal_start = (state_q == StGranted) ? grant_q : '0;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    snd_data_d  = snd_data_q;
    snd_flags_d = snd_flags_q;
    snd_start_d = 1'b0;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    tmo_d       = 1'b0;
    perr_d      = |(cli_start & ~legal_start);

    unique case (state_q)
      StIdle: begin
        if (|cli_req) begin
          grant_d            = '0;
          grant_d[rr_winner] = 1'b1;
          owner_d            = rr_winner;
          state_d            = StGranted;
        end
      end
      StGranted: begin
        if (!cli_req[owner_q]) begin
          state_d = StRelease;
        end else if (cli_start[owner_q]) begin
          snd_data_d  = cli_data[owner_q];
          snd_flags_d = cli_flags[owner_q];
          snd_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = StInFlight;
        end
      end
      StInFlight: begin
        // A real completion beats a coincident watchdog expiry.
        if (snd_done || (cnt_q == CW'(TIMEOUT_CYC - 1))) begin
          done_d  = grant_q;
          tmo_d   = !snd_done;
          state_d = cli_req[owner_q] ? StGranted : StRelease;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        grant_d     = '0;
        last_d      = owner_q;
        snd_flags_d = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      done_q      <= '0;
      snd_data_q  <= '0;
      snd_flags_q <= '0;
      snd_start_q <= 1'b0;
      busy_q      <= 1'b0;
      owner_q     <= '0;
      last_q      <= OW'(N_REQ - 1);
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      snd_data_q  <= snd_data_d;
      snd_flags_q <= snd_flags_d;
      snd_start_q <= snd_start_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      perr_q      <= perr_d;
    end
  end

  assign cli_grant   = grant_q;
  assign cli_done    = done_q;
  assign snd_data    = snd_data_q;
  assign snd_flags   = snd_flags_q;
  assign snd_start   = snd_start_q;
  assign busy        = busy_q;
  assign owner_id    = owner_q;
  assign timeout_err = tmo_q;
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_matrix_sender_arbiter.sv
// Directed bench for matrix_sender_arbiter: scoreboard queues for sender commands and
// owner completions, immediate assertions at every comparison.
module tb_matrix_sender_arbiter;

  localparam int unsigned NR  = 3;
  localparam int unsigned DW  = 8;
  localparam int unsigned TMO = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NR-1:0]          cli_req = '0;
  logic [NR-1:0]          cli_start = '0;
  logic [NR-1:0][DW-1:0]  cli_data = '0;
  logic [NR-1:0][4:0]     cli_flags = '0;
  logic                   snd_done = 1'b0;

  logic [NR-1:0]          cli_grant;
  logic [NR-1:0]          cli_done;
  logic [DW-1:0]          snd_data;
  logic [4:0]             snd_flags;
  logic                   snd_start;
  logic                   busy;
  logic [1:0]             owner_id;
  logic                   timeout_err;
  logic                   proto_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [12:0] exp_snd_q[$];
  logic [2:0]  exp_done_q[$];
  logic [12:0] mon_snd;
  logic [2:0]  mon_done;
  logic [7:0]  dv[3] = '{8'd5, 8'd7, 8'hFD};

  matrix_sender_arbiter #(
    .N_REQ      (NR),
    .DATA_WIDTH (DW),
    .TIMEOUT_CYC(TMO),
    .OW         (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cli_req    (cli_req),
    .cli_start  (cli_start),
    .cli_data   (cli_data),
    .cli_flags  (cli_flags),
    .cli_grant  (cli_grant),
    .cli_done   (cli_done),
    .snd_data   (snd_data),
    .snd_flags  (snd_flags),
    .snd_start  (snd_start),
    .snd_done   (snd_done),
    .busy       (busy),
    .owner_id   (owner_id),
    .timeout_err(timeout_err),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] oh(input int r);
    return 3'(1 << r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sender commands and owner completions are matched against what the stimulus queued.
  always @(negedge clk) begin
    chk("grant_onehot0", 32'($onehot0(cli_grant)), 32'd1);
    if (snd_start === 1'b1) begin
      if (exp_snd_q.size() == 0) begin
        chk("unexpected_snd_start", 32'(snd_start), 32'd0);
      end else begin
        mon_snd = exp_snd_q.pop_front();
        chk("sb_snd_data", 32'(snd_data), 32'(mon_snd[12:5]));
        chk("sb_snd_flags", 32'(snd_flags), 32'(mon_snd[4:0]));
      end
    end
    if (cli_done !== 3'b000) begin
      if (exp_done_q.size() == 0) begin
        chk("unexpected_cli_done", 32'(cli_done), 32'd0);
      end else begin
        mon_done = exp_done_q.pop_front();
        chk("sb_cli_done", 32'(cli_done), 32'(mon_done));
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, 32'(cli_grant), 32'd0);
    chk({tag, "_done"}, 32'(cli_done), 32'd0);
    chk({tag, "_snd_data"}, 32'(snd_data), 32'd0);
    chk({tag, "_snd_flags"}, 32'(snd_flags), 32'd0);
    chk({tag, "_snd_start"}, 32'(snd_start), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_owner"}, 32'(owner_id), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
    chk({tag, "_proto"}, 32'(proto_err), 32'd0);
  endtask

  task automatic do_start(input int r, input logic [7:0] d, input logic [4:0] f);
    cli_start[r] = 1'b1;
    cli_data[r]  = d;
    cli_flags[r] = f;
    exp_snd_q.push_back({d, f});
    tick();
    cli_start = '0;
    chk("snd_start_latency", 32'(snd_start), 32'd1);
  endtask

  task automatic send_done(input int r);
    snd_done = 1'b1;
    exp_done_q.push_back(oh(r));
    tick();
    snd_done = 1'b0;
    chk("cli_done_latency", 32'(cli_done), 32'(oh(r)));
  endtask

  task automatic end_session(input int r, input bit re_raise);
    cli_req[r] = 1'b0;
    tick();
    chk("release_grant_held", 32'(cli_grant), 32'(oh(r)));
    tick();
    chk("gap_grant_zero", 32'(cli_grant), 32'd0);
    chk("gap_busy_zero", 32'(busy), 32'd0);
    if (re_raise) cli_req[r] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    // Reset with all requests already pending.
    cli_req = 3'b111;
    tick();
    tick();
    check_zero("reset");

    // Round-robin: expected grant order 0, 1, 2, 0.
    rst = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant", 32'(cli_grant), 32'(oh(k % 3)));
      chk("rr_owner", 32'(owner_id), 32'(k % 3));
      chk("rr_busy", 32'(busy), 32'd1);
      do_start(k % 3, 8'(8'h10 + k), 5'(k));
      tick();
      send_done(k % 3);
      end_session(k % 3, k == 0);
      if (k < 3) tick();
    end

    // Single session from requester 0: 5, 7, -3 back to back.
    cli_req[0] = 1'b1;
    tick();
    chk("single_grant", 32'(cli_grant), 32'd1);
    for (int i = 0; i < 3; i++) begin
      do_start(0, dv[i], (i == 2) ? 5'b00001 : 5'b00000);
      tick();
      chk("snd_start_one_cycle", 32'(snd_start), 32'd0);
      chk("snd_data_hold1", 32'(snd_data), 32'(dv[i]));
      tick();
      chk("snd_data_hold2", 32'(snd_data), 32'(dv[i]));
      send_done(0);
    end
    tick();
    chk("single_done_cleared", 32'(cli_done), 32'd0);

    // Protocol errors: non-owner start in GRANTED, owner start while in flight.
    cli_start[1] = 1'b1;
    cli_data[1]  = 8'h55;
    tick();
    cli_start = '0;
    chk("perr_nonowner", 32'(proto_err), 32'd1);
    chk("perr_nonowner_no_start", 32'(snd_start), 32'd0);
    tick();
    chk("perr_pulse_end", 32'(proto_err), 32'd0);
    chk("perr_grant_kept", 32'(cli_grant), 32'd1);
    do_start(0, 8'h22, 5'b00010);
    cli_start[0] = 1'b1;
    cli_data[0]  = 8'h99;
    tick();
    cli_start = '0;
    chk("perr_inflight", 32'(proto_err), 32'd1);
    chk("perr_inflight_no_start", 32'(snd_start), 32'd0);
    chk("perr_data_stable", 32'(snd_data), 32'h22);
    tick();
    chk("perr_pulse_end2", 32'(proto_err), 32'd0);
    send_done(0);
    end_session(0, 1'b0);

    // Watchdog: requester 2, sender never answers.
    cli_req[2] = 1'b1;
    tick();
    chk("wd_grant", 32'(cli_grant), 32'(oh(2)));
    do_start(2, 8'h3C, 5'b10000);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("wd_no_timeout_yet", 32'(timeout_err), 32'd0);
    end
    exp_done_q.push_back(oh(2));
    tick();
    chk("wd_timeout_err", 32'(timeout_err), 32'd1);
    chk("wd_cli_done", 32'(cli_done), 32'(oh(2)));
    tick();
    chk("wd_timeout_pulse_end", 32'(timeout_err), 32'd0);
    chk("wd_still_granted", 32'(cli_grant), 32'(oh(2)));
    do_start(2, 8'h3D, 5'b01000);
    tick();
    send_done(2);
    end_session(2, 1'b0);

    // Requester 1 drops req mid-flight; element still completes.
    cli_req[1] = 1'b1;
    tick();
    chk("drop_grant", 32'(cli_grant), 32'(oh(1)));
    do_start(1, 8'h41, 5'b00000);
    cli_req[1] = 1'b0;
    tick();
    tick();
    chk("drop_grant_held", 32'(cli_grant), 32'(oh(1)));
    chk("drop_data_held", 32'(snd_data), 32'h41);
    send_done(1);
    tick();
    chk("drop_released", 32'(cli_grant), 32'd0);

    // snd_done on the exact watchdog expiry cycle.
    cli_req[1] = 1'b1;
    tick();
    chk("coin_grant", 32'(cli_grant), 32'(oh(1)));
    do_start(1, 8'h42, 5'b00000);
    repeat (15) tick();
    send_done(1);
    chk("coin_no_timeout", 32'(timeout_err), 32'd0);
    tick();
    chk("coin_no_timeout_late", 32'(timeout_err), 32'd0);
    chk("coin_done_once", 32'(cli_done), 32'd0);
    end_session(1, 1'b0);

    // Reset three cycles after snd_start.
    cli_req[0] = 1'b1;
    tick();
    chk("rstmid_grant", 32'(cli_grant), 32'd1);
    do_start(0, 8'h77, 5'b00100);
    repeat (3) tick();
    rst     = 1'b1;
    cli_req = '0;
    tick();
    check_zero("rstmid");
    rst = 1'b0;
    tick();
    snd_done = 1'b1;
    tick();
    snd_done = 1'b0;
    chk("rstmid_done_ignored", 32'(cli_done), 32'd0);
    tick();
    chk("rstmid_done_ignored2", 32'(cli_done), 32'd0);
    cli_req[0] = 1'b1;
    tick();
    chk("rstmid_regrant", 32'(cli_grant), 32'd1);
    chk("rstmid_owner", 32'(owner_id), 32'd0);
    end_session(0, 1'b0);

    tick();
    chk("snd_queue_drained", 32'(exp_snd_q.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
